pc_sequencer: RTL and testbench

//   Parametrised program-counter register and next-PC generator for the CPU datapath.

---
 rtl/pc_seq_if.sv | 27 ++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Control-unit <-> PC sequencer bundle: redirect/stall/halt requests in, fetch address and status out.
interface pc_seq_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_tgt;
  logic              br_taken;
  logic [ADDR_W-1:0] br_off;
  logic              halt_req;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              pc_valid;
  logic [1:0]        state;
  logic              err;

  modport master (
    output stall, jmp_en, jmp_tgt, br_taken, br_off, halt_req, resume,
    input  pc, pc_plus, pc_valid, state, err
  );

  modport slave (
    input  stall, jmp_en, jmp_tgt, br_taken, br_off, halt_req, resume,
    output pc, pc_plus, pc_valid, state, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with jump/branch redirect, stall and BOOT/RUN/HALT sequencing.
// Define PC_ALIGN_CHK_EN to trap misaligned redirects to TRAP_VEC with a sticky err flag.
module pc_sequencer #(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0080)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  pc_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10,
    StBad  = 2'b11
  } state_e;

  // Low bits that must be zero in any fetch address.
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] StepVal   = ADDR_W'(STEP);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              redirect;
  logic [ADDR_W-1:0] tgt;

`ifdef PC_ALIGN_CHK_EN
  logic err_q, err_d;
`endif

  assign redirect = bus.jmp_en | bus.br_taken;
  assign tgt      = bus.jmp_en ? bus.jmp_tgt : (pc_q + bus.br_off);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
`ifdef PC_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
      StRun: begin
        valid_d = 1'b1;
        if (redirect) begin
`ifdef PC_ALIGN_CHK_EN
          if ((tgt & AlignMask) != '0) begin
            pc_d  = TRAP_VEC;
            err_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
`else
          pc_d = tgt & ~AlignMask;
`endif
        end else if (!bus.stall) begin
          pc_d = pc_q + StepVal;
        end
        // The pc update above still lands on the halting cycle.
        if (bus.halt_req) begin
          state_d = StHalt;
          valid_d = 1'b0;
        end
      end
      StHalt: begin
        if (bus.resume && !bus.halt_req) begin
          state_d = StRun;
          valid_d = 1'b1;
        end
      end
      StBad: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
      default: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StBoot;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_q + StepVal;
  assign bus.pc_valid = valid_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stepping, redirects, wrap, halt/resume, alignment.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_seq_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W   (32),
    .STEP     (4),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0080)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall    = 1'b0;
    bus.jmp_en   = 1'b0;
    bus.jmp_tgt  = '0;
    bus.br_taken = 1'b0;
    bus.br_off   = '0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;
  endtask

  task automatic jump(input logic [31:0] t);
    clear_inputs();
    bus.jmp_en  = 1'b1;
    bus.jmp_tgt = t;
    step();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #3;
    // Reset state
    check("rst_pc", bus.pc, 32'h0);
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_valid", 32'(bus.pc_valid), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_pc_plus", bus.pc_plus, 32'h4);
    step();
    rst_n = 1'b1;
    step();
    check("boot_state", 32'(bus.state), 32'h1);
    check("boot_valid", 32'(bus.pc_valid), 32'h1);
    check("boot_pc", bus.pc, 32'h0);
    step();
    check("seq_pc4", bus.pc, 32'h4);
    step();
    check("seq_pc8", bus.pc, 32'h8);
    step();
    check("seq_pcC", bus.pc, 32'hC);

    // Backward branch, then with stall asserted
    jump(32'h100);
    check("jmp_100", bus.pc, 32'h100);
    bus.br_taken = 1'b1;
    bus.br_off   = 32'hFFFF_FFF8;
    step();
    check("br_back", bus.pc, 32'hF8);
    jump(32'h100);
    bus.br_taken = 1'b1;
    bus.br_off   = 32'hFFFF_FFF8;
    bus.stall    = 1'b1;
    step();
    check("br_stall", bus.pc, 32'hF8);
    clear_inputs();
    bus.stall = 1'b1;
    step();
    check("stall_hold", bus.pc, 32'hF8);
    clear_inputs();

    // Jump beats branch
    bus.jmp_en   = 1'b1;
    bus.jmp_tgt  = 32'h400;
    bus.br_taken = 1'b1;
    bus.br_off   = 32'h10;
    step();
    check("jmp_prio", bus.pc, 32'h400);
    clear_inputs();
    bus.br_taken = 1'b1;
    bus.br_off   = 32'h10;
    step();
    check("br_fwd", bus.pc, 32'h410);
    clear_inputs();

    // Sequential wrap
    jump(32'hFFFF_FFFC);
    check("wrap_pc_plus", bus.pc_plus, 32'h0);
    step();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_err", 32'(bus.err), 32'h0);

    // Halt / resume
    jump(32'h20);
    bus.halt_req = 1'b1;
    step();
    check("halt_state", 32'(bus.state), 32'h2);
    check("halt_valid", 32'(bus.pc_valid), 32'h0);
    check("halt_pc", bus.pc, 32'h24);
    clear_inputs();
    bus.jmp_en  = 1'b1;
    bus.jmp_tgt = 32'h300;
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_hold_pc", bus.pc, 32'h24);
      check("halt_hold_state", 32'(bus.state), 32'h2);
    end
    clear_inputs();
    bus.resume   = 1'b1;
    bus.halt_req = 1'b1;
    step();
    check("resume_blocked", 32'(bus.state), 32'h2);
    bus.halt_req = 1'b0;
    step();
    check("resume_state", 32'(bus.state), 32'h1);
    check("resume_valid", 32'(bus.pc_valid), 32'h1);
    check("resume_pc", bus.pc, 32'h24);
    clear_inputs();
    step();
    check("resume_step", bus.pc, 32'h28);

    // Halt with same-cycle redirect, then with stall
    bus.halt_req = 1'b1;
    bus.jmp_en   = 1'b1;
    bus.jmp_tgt  = 32'h500;
    step();
    check("halt_jmp_pc", bus.pc, 32'h500);
    check("halt_jmp_state", 32'(bus.state), 32'h2);
    clear_inputs();
    bus.resume = 1'b1;
    step();
    clear_inputs();
    bus.halt_req = 1'b1;
    bus.stall    = 1'b1;
    step();
    check("halt_stall_pc", bus.pc, 32'h500);
    clear_inputs();
    bus.resume = 1'b1;
    step();
    clear_inputs();

    // Misaligned redirect
    jump(32'h202);
`ifdef PC_ALIGN_CHK_EN
    check("misalign_pc", bus.pc, 32'h80);
    check("misalign_err", 32'(bus.err), 32'h1);
    check("misalign_state", 32'(bus.state), 32'h1);
    step();
    check("misalign_next", bus.pc, 32'h84);
    check("misalign_sticky", 32'(bus.err), 32'h1);
`else
    check("misalign_pc", bus.pc, 32'h200);
    check("misalign_err", 32'(bus.err), 32'h0);
    check("misalign_state", 32'(bus.state), 32'h1);
    step();
    check("misalign_next", bus.pc, 32'h204);
    check("misalign_sticky", 32'(bus.err), 32'h0);
`endif

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", bus.pc, 32'h0);
    check("async_state", 32'(bus.state), 32'h0);
    check("async_valid", 32'(bus.pc_valid), 32'h0);
    check("async_err", 32'(bus.err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
